// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle for regfile_wb_arbiter.
//   master : the pipeline side (drives the ALU/load/link requests, sees the results)
//   slave  : the arbiter itself
// Signals:
//   alu_valid/alu_ready/alu_addr/alu_data : ALU writeback handshake
//   mem_valid/mem_ready/mem_addr/mem_data : load writeback handshake
//   lnk_valid/lnk_data                    : JAL link value (no backpressure)
//   wen/waddr/wdata                       : register file write port
//   r15/r15enable                         : dedicated R15 write path
//   pend                                  : per-register pending-write mask
//   busy                                  : any write queued or issuing
interface regfile_wb_arbiter_if #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4,
  parameter int NREG  = 16
);
  logic             alu_valid;
  logic             alu_ready;
  logic [RSIZE-1:0] alu_addr;
  logic [DSIZE-1:0] alu_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [RSIZE-1:0] mem_addr;
  logic [DSIZE-1:0] mem_data;
  logic             lnk_valid;
  logic [DSIZE-1:0] lnk_data;
  logic             wen;
  logic [RSIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata;
  logic [DSIZE-1:0] r15;
  logic             r15enable;
  logic [NREG-1:0]  pend;
  logic             busy;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output lnk_valid, lnk_data,
    input  alu_ready, mem_ready,
    input  wen, waddr, wdata, r15, r15enable, pend, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  lnk_valid, lnk_data,
    output alu_ready, mem_ready,
    output wen, waddr, wdata, r15, r15enable, pend, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Each source (ALU, load) is buffered in a QDEPTH-entry FIFO; the two FIFO
// heads are arbitrated every cycle and the winner is registered onto
// wen/waddr/wdata. Same-register writes leave in acceptance order via a
// wrapping sequence tag; different registers are served round-robin.
// The JAL link value is registered onto r15/r15enable independently.
// Ports: clk, rst (asynchronous, active-low), bus (regfile_wb_arbiter_if.slave).
// Optional build macro: WB_SCOREBOARD_EN builds the pend mask; when it is
// undefined pend is tied to 0.
module regfile_wb_arbiter #(
  parameter int DSIZE  = 16,
  parameter int RSIZE  = 4,
  parameter int NREG   = 16,
  parameter int QDEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int TAGW = $clog2(2 * QDEPTH) + 1;
  localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW   = $clog2(QDEPTH + 1);
  localparam int ALU  = 0;
  localparam int MEM  = 1;
  localparam logic [RSIZE-1:0] ZERO_REG = '0;
  localparam logic [RSIZE-1:0] LINK_REG = RSIZE'(15);
  localparam logic [CW-1:0]    FULL_CNT = CW'(QDEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Modulo age compare: a is older than b when a-b is "negative".
  function automatic logic older(input logic [TAGW-1:0] a, input logic [TAGW-1:0] b);
    logic [TAGW-1:0] d;
    d = a - b;
    return d[TAGW-1];
  endfunction

  logic [RSIZE-1:0] q_addr [2][QDEPTH];
  logic [DSIZE-1:0] q_data [2][QDEPTH];
  logic [TAGW-1:0]  q_tag  [2][QDEPTH];
  logic [PW-1:0]    rptr   [2];
  logic [PW-1:0]    wptr   [2];
  logic [CW-1:0]    cnt    [2];
  logic [TAGW-1:0]  tag_cnt;
  logic             last_mem;

  logic             wen_q;
  logic [RSIZE-1:0] waddr_q;
  logic [DSIZE-1:0] wdata_q;
  logic [DSIZE-1:0] r15_q;
  logic             r15en_q;

  logic [1:0]       in_vld, rdy, enq, hv, gnt;
  logic [RSIZE-1:0] in_addr [2];
  logic [DSIZE-1:0] in_data [2];
  logic [TAGW-1:0]  in_tag  [2];
  logic [RSIZE-1:0] h_addr  [2];
  logic [DSIZE-1:0] h_data  [2];
  logic [TAGW-1:0]  h_tag   [2];

  assign in_vld        = {bus.mem_valid, bus.alu_valid};
  assign in_addr[ALU]  = bus.alu_addr;
  assign in_addr[MEM]  = bus.mem_addr;
  assign in_data[ALU]  = bus.alu_data;
  assign in_data[MEM]  = bus.mem_data;
  // The load is the older instruction when both enqueue together.
  assign in_tag[MEM]   = tag_cnt;
  assign in_tag[ALU]   = tag_cnt + TAGW'(enq[MEM]);

  always_comb begin
    rdy = '0;
    enq = '0;
    hv  = '0;
    for (int s = 0; s < 2; s++) begin
      rdy[s]    = (cnt[s] != FULL_CNT);
      // R0 and R15 writes complete the handshake but are discarded.
      enq[s]    = in_vld[s] && rdy[s] && (in_addr[s] != ZERO_REG) && (in_addr[s] != LINK_REG);
      hv[s]     = (cnt[s] != '0);
      h_addr[s] = q_addr[s][rptr[s]];
      h_data[s] = q_data[s][rptr[s]];
      h_tag[s]  = q_tag[s][rptr[s]];
    end
  end

  always_comb begin
    gnt = hv;
    if (hv == 2'b11) begin
      if (h_addr[ALU] == h_addr[MEM]) gnt = older(h_tag[MEM], h_tag[ALU]) ? 2'b10 : 2'b01;
      else                            gnt = last_mem ? 2'b01 : 2'b10;
    end
  end

  assign bus.alu_ready = rdy[ALU];
  assign bus.mem_ready = rdy[MEM];

  // ---- stage boundary: FIFO storage (data only, not reset) ----
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (enq[s]) begin
        q_addr[s][wptr[s]] <= in_addr[s];
        q_data[s][wptr[s]] <= in_data[s];
        q_tag[s][wptr[s]]  <= in_tag[s];
      end
    end
  end

  // ---- stage boundary: FIFO control, issue register, link register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        rptr[s] <= '0;
        wptr[s] <= '0;
        cnt[s]  <= '0;
      end
      tag_cnt  <= '0;
      last_mem <= 1'b1;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      r15_q    <= '0;
      r15en_q  <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (enq[s]) wptr[s] <= ptr_inc(wptr[s]);
        if (gnt[s]) rptr[s] <= ptr_inc(rptr[s]);
        cnt[s] <= cnt[s] + CW'(enq[s]) - CW'(gnt[s]);
      end
      tag_cnt <= tag_cnt + TAGW'(enq[ALU]) + TAGW'(enq[MEM]);
      wen_q   <= |gnt;
      if (|gnt) begin
        last_mem <= gnt[MEM];
        waddr_q  <= gnt[MEM] ? h_addr[MEM] : h_addr[ALU];
        wdata_q  <= gnt[MEM] ? h_data[MEM] : h_data[ALU];
      end
      r15en_q <= bus.lnk_valid;
      if (bus.lnk_valid) r15_q <= bus.lnk_data;
    end
  end

  assign bus.wen       = wen_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.r15       = r15_q;
  assign bus.r15enable = r15en_q;
  assign bus.busy      = hv[ALU] | hv[MEM] | wen_q;

`ifdef WB_SCOREBOARD_EN
  logic [QDEPTH-1:0] q_vld [2];
  logic [NREG-1:0]   pend_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_vld[ALU] <= '0;
      q_vld[MEM] <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (gnt[s]) q_vld[s][rptr[s]] <= 1'b0;
        if (enq[s]) q_vld[s][wptr[s]] <= 1'b1;
      end
    end
  end

  always_comb begin
    pend_c = '0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < QDEPTH; j++) begin
        if (q_vld[s][j]) pend_c[q_addr[s][j]] = 1'b1;
      end
    end
    if (wen_q) pend_c[waddr_q] = 1'b1;
  end

  assign bus.pend = pend_c;
`else
  assign bus.pend = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int DS = 16;
  localparam int RS = 4;
  localparam int NR = 16;
  localparam int QD = 2;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DSIZE(DS), .RSIZE(RS), .NREG(NR)) bus ();

  regfile_wb_arbiter #(.DSIZE(DS), .RSIZE(RS), .NREG(NR), .QDEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, unbounded sequence numbers.
  typedef struct packed {
    logic [RS-1:0] addr;
    logic [DS-1:0] data;
    logic [31:0]   seq;
  } ent_t;

  ent_t          q_a[$];
  ent_t          q_m[$];
  logic [31:0]   m_seq      = '0;
  bit            m_last_mem = 1'b1;
  logic          m_wen      = 1'b0;
  logic          m_r15en    = 1'b0;
  logic [RS-1:0] m_waddr    = '0;
  logic [DS-1:0] m_wdata    = '0;
  logic [DS-1:0] m_r15      = '0;
  bit            a_acc, m_acc, g_a, g_m;

  function automatic bit kept(input logic [RS-1:0] a);
    return (a != 0) && (a != 15);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_a.delete();
      q_m.delete();
      m_seq = '0; m_last_mem = 1'b1;
      m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
      m_r15 = '0; m_r15en = 1'b0;
    end else begin
      a_acc = (bus.alu_valid === 1'b1) && (q_a.size() < QD);
      m_acc = (bus.mem_valid === 1'b1) && (q_m.size() < QD);
      if (q_a.size() > 0 && q_m.size() > 0) begin
        if (q_a[0].addr == q_m[0].addr) g_m = (q_m[0].seq < q_a[0].seq);
        else                            g_m = !m_last_mem;
        g_a = !g_m;
      end else begin
        g_a = (q_a.size() > 0);
        g_m = (q_m.size() > 0);
      end
      m_wen = g_a || g_m;
      if (g_m) begin
        m_waddr = q_m[0].addr; m_wdata = q_m[0].data;
        void'(q_m.pop_front());
        m_last_mem = 1'b1;
      end
      if (g_a) begin
        m_waddr = q_a[0].addr; m_wdata = q_a[0].data;
        void'(q_a.pop_front());
        m_last_mem = 1'b0;
      end
      if (m_acc && kept(bus.mem_addr)) begin
        q_m.push_back('{bus.mem_addr, bus.mem_data, m_seq});
        m_seq++;
      end
      if (a_acc && kept(bus.alu_addr)) begin
        q_a.push_back('{bus.alu_addr, bus.alu_data, m_seq});
        m_seq++;
      end
      m_r15en = bus.lnk_valid;
      if (bus.lnk_valid) m_r15 = bus.lnk_data;
    end
  end

  // Per-cycle compare, plus a log of issued writes and a shadow register file.
  logic [RS+DS-1:0] wlog[$];
  logic [DS-1:0]    rf [NR];
  logic [NR-1:0]    e_pend;

  always @(negedge clk) begin
    e_pend = '0;
    if (SB) begin
      foreach (q_a[i]) e_pend[q_a[i].addr] = 1'b1;
      foreach (q_m[i]) e_pend[q_m[i].addr] = 1'b1;
      if (m_wen) e_pend[m_waddr] = 1'b1;
    end
    chk("alu_ready", bus.alu_ready, q_a.size() < QD);
    chk("mem_ready", bus.mem_ready, q_m.size() < QD);
    chk("wen",       bus.wen,       m_wen);
    chk("waddr",     bus.waddr,     m_waddr);
    chk("wdata",     bus.wdata,     m_wdata);
    chk("r15enable", bus.r15enable, m_r15en);
    chk("r15",       bus.r15,       m_r15);
    chk("pend",      bus.pend,      e_pend);
    chk("busy",      bus.busy,      (q_a.size() > 0) || (q_m.size() > 0) || m_wen);
    if (bus.wen === 1'b1) begin
      wlog.push_back({bus.waddr, bus.wdata});
      rf[bus.waddr] = bus.wdata;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.lnk_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [RS-1:0] a, input logic [DS-1:0] d);
    bus.alu_valid = 1'b1; bus.alu_addr = a; bus.alu_data = d;
  endtask

  task automatic drive_mem(input logic [RS-1:0] a, input logic [DS-1:0] d);
    bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
    wlog.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int a_sent, m_sent;
  bit saw_a_full, saw_m_full;
  logic [RS-1:0] ra;

  initial begin
    bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_addr = '0; bus.mem_data = '0;
    bus.lnk_data = '0;
    idle();
    step();
    do_reset();

    // Reset values
    chk("rst_wen", bus.wen, 1'b0);
    chk("rst_waddr", bus.waddr, 4'd0);
    chk("rst_wdata", bus.wdata, 16'h0);
    chk("rst_r15", bus.r15, 16'h0);
    chk("rst_r15en", bus.r15enable, 1'b0);
    chk("rst_pend", bus.pend, 16'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_alu_ready", bus.alu_ready, 1'b1);
    chk("rst_mem_ready", bus.mem_ready, 1'b1);

    // Single ALU write, addr 3 data 0x1234
    drive_alu(4'd3, 16'h1234);
    step();
    idle();
    chk("single_wen_e0", bus.wen, 1'b0);
    chk("single_pend3_e0", bus.pend[3], SB);
    chk("single_busy_e0", bus.busy, 1'b1);
    step();
    chk("single_wen", bus.wen, 1'b1);
    chk("single_waddr", bus.waddr, 4'd3);
    chk("single_wdata", bus.wdata, 16'h1234);
    chk("single_pend3_e1", bus.pend[3], SB);
    step();
    chk("single_wen_off", bus.wen, 1'b0);
    chk("single_busy_off", bus.busy, 1'b0);
    chk("single_pend_off", bus.pend, 16'h0);

    // Same register from both sources in one cycle: load first
    wlog.delete();
    drive_alu(4'd7, 16'hAAAA);
    drive_mem(4'd7, 16'hBBBB);
    step();
    idle();
    step(); step(); step();
    chk("same_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("same_first", wlog[0], {4'd7, 16'hBBBB});
      chk("same_second", wlog[1], {4'd7, 16'hAAAA});
    end
    chk("same_rf7", rf[7], 16'hAAAA);

    // R0 / R15 writes are accepted and dropped
    wlog.delete();
    chk("drop_ready0", bus.alu_ready, 1'b1);
    drive_alu(4'd0, 16'h5555);
    step();
    chk("drop_ready15", bus.alu_ready, 1'b1);
    drive_alu(4'd15, 16'h6666);
    step();
    idle();
    step(); step(); step();
    chk("drop_nowrite", wlog.size(), 0);
    chk("drop_busy", bus.busy, 1'b0);

    // Back-to-back link writes alongside ALU traffic
    drive_alu(4'd4, 16'h0011);
    bus.lnk_valid = 1'b1; bus.lnk_data = 16'h0040;
    step();
    chk("lnk_en0", bus.r15enable, 1'b1);
    chk("lnk_r15_0", bus.r15, 16'h0040);
    drive_alu(4'd4, 16'h0022);
    bus.lnk_data = 16'h0050;
    step();
    idle();
    chk("lnk_en1", bus.r15enable, 1'b1);
    chk("lnk_r15_1", bus.r15, 16'h0050);
    chk("lnk_alu_wen0", bus.wen, 1'b1);
    chk("lnk_alu_data0", bus.wdata, 16'h0011);
    step();
    chk("lnk_en_off", bus.r15enable, 1'b0);
    chk("lnk_r15_hold", bus.r15, 16'h0050);
    chk("lnk_alu_wen1", bus.wen, 1'b1);
    chk("lnk_alu_data1", bus.wdata, 16'h0022);
    step();
    chk("lnk_alu_off", bus.wen, 1'b0);

    // Contended different registers: round-robin, ALU first after reset
    do_reset();
    a_sent = 0; m_sent = 0; saw_a_full = 0; saw_m_full = 0;
    for (int i = 0; i < 12; i++) begin
      drive_alu(4'd2, 16'(16'h0100 + a_sent));
      drive_mem(4'd5, 16'(16'h0200 + m_sent));
      if (bus.alu_ready) a_sent++; else saw_a_full = 1'b1;
      if (bus.mem_ready) m_sent++; else saw_m_full = 1'b1;
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();
    chk("rr_total", wlog.size(), a_sent + m_sent);
    chk("rr_alu_full_seen", saw_a_full, 1'b1);
    chk("rr_mem_full_seen", saw_m_full, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i < wlog.size())
        chk("rr_order", wlog[i], (i % 2 == 0) ? {4'd2, 16'(16'h0100 + i / 2)}
                                              : {4'd5, 16'(16'h0200 + i / 2)});
    end

    // Asynchronous reset in the middle of a cycle with both FIFOs busy
    for (int i = 0; i < 6; i++) begin
      drive_alu(4'd9, 16'(16'h0900 + i));
      drive_mem(4'd10, 16'(16'h0A00 + i));
      bus.lnk_valid = 1'b1; bus.lnk_data = 16'h0077;
      step();
    end
    @(posedge clk);
    #2;
    chk("mrst_pre_wen", bus.wen, 1'b1);
    chk("mrst_pre_busy", bus.busy, 1'b1);
    chk("mrst_pre_r15en", bus.r15enable, 1'b1);
    rst = 1'b0;
    #1;
    idle();
    chk("mrst_wen", bus.wen, 1'b0);
    chk("mrst_r15en", bus.r15enable, 1'b0);
    chk("mrst_pend", bus.pend, 16'h0);
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_alu_ready", bus.alu_ready, 1'b1);
    chk("mrst_mem_ready", bus.mem_ready, 1'b1);
    step();
    step();
    rst = 1'b1;
    wlog.delete();
    for (int i = 0; i < 4; i++) step();
    chk("mrst_no_stale", wlog.size(), 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? RS'($urandom_range(0, 15)) : RS'($urandom_range(1, 3));
      bus.alu_valid = ($urandom_range(0, 2) != 0);
      bus.alu_addr  = ra;
      bus.alu_data  = DS'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? RS'($urandom_range(0, 15)) : RS'($urandom_range(1, 3));
      bus.mem_valid = ($urandom_range(0, 2) != 0);
      bus.mem_addr  = ra;
      bus.mem_data  = DS'($urandom);
      bus.lnk_valid = ($urandom_range(0, 3) == 0);
      bus.lnk_data  = DS'($urandom);
      step();
    end
    idle();
    for (int i = 0; i < 10; i++) step();
    chk("rand_drained", q_a.size() + q_m.size(), 0);
    chk("rand_busy", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and sequencer for the 16-entry register file's single write port. Two writeback sources feed it through valid/ready handshakes: the ALU stage and the memory-load stage. It buffers each source in a small FIFO and issues at most one write per cycle onto the register file's `wen`/`waddr`/`wdata` port, keeping same-register writes in acceptance order. It also registers the JAL link value onto the dedicated R15 path (`r15`/`r15enable`).

## Interface
Reset is asynchronous and active-low. The reset port keeps the codebase name `rst`.

Parameters:
- DSIZE, 16, data width.
- RSIZE, 4, register address width.
- NREG, 16, number of registers (width of `pend`).
- QDEPTH, 2, FIFO depth per source. Legal range is 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU FIFO can accept.
- alu_addr  in  RSIZE  ALU destination register.
- alu_data  in  DSIZE  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load FIFO can accept.
- mem_addr  in  RSIZE  load destination register.
- mem_data  in  DSIZE  load data.
- lnk_valid  in  1  JAL link write; no backpressure.
- lnk_data  in  DSIZE  link (return) address.
- wen  out  1  register file write enable.
- waddr  out  RSIZE  register file write address.
- wdata  out  DSIZE  register file write data.
- r15  out  DSIZE  value for R15.
- r15enable  out  1  R15 write strobe.
- pend  out  NREG  pending-write mask; bit i is set while a write to register i is queued or being issued.
- busy  out  1  high if either FIFO is non-empty or `wen` is high.

## Operation
- Acceptance:
  - A transfer occurs when `x_valid && x_ready`.
  - `x_ready` is `!full`, computed from the registered count only. There is no same-cycle pass-through: a full FIFO stays not-ready even while it is dequeuing.
- Drop rule: an accepted entry with address 0 or 15 is consumed by the handshake but never enqueued or issued.
- Sequence tags:
  - Every enqueued entry carries a tag from a global accept counter. Tag width is clog2(2*QDEPTH)+1 bits, and the counter wraps.
  - If both sources are accepted in the same cycle, mem takes tag n and alu takes n+1, because the load is the older instruction.
  - Tag age is compared modulo: A is older than B when the MSB of (A−B) is set.
- Arbitration, evaluated each cycle on the two FIFO heads:
  - If only one head is valid, that head is granted.
  - If both heads are valid with different addresses, grant round-robin: the source not granted last time wins.
  - If both heads are valid with the same address, the older tag wins.
  - `last_grant` updates to the winner in every case.
- Issue: the granted head is dequeued, and `wen`/`waddr`/`wdata` are registered from it. When nothing is granted, `wen`=0 and `waddr`/`wdata` hold their previous values.
- Link path: `lnk_valid` at edge E loads `r15`←`lnk_data` and sets `r15enable`=1 for exactly one cycle. Back-to-back link requests give consecutive pulses. The link path is independent of arbitration.
- FIFO pointers wrap modulo QDEPTH. The count is never allowed to exceed QDEPTH or go below 0.

## Timing
- Reset values: `wen`=0, `waddr`=0, `wdata`=0, `r15`=0, `r15enable`=0, `pend`=0, `busy`=0, `alu_ready`=`mem_ready`=1.
- Reset state: FIFOs empty, tag counter 0, `last_grant`=mem so that ALU wins the first contended round-robin.
- Asserting `rst` mid-operation clears all state immediately. Queued writes are discarded, and an in-flight `wen` drops without waiting for a clock edge.
- Latency:
  - A transfer accepted at edge E0 gives `wen`=1 during the cycle after E1, when uncontended.
  - Each cycle of losing arbitration adds one cycle.
  - Link writes: `r15enable` is high during the cycle after the accepting edge.
- Throughput: one register file write per cycle. A source winning every cycle sustains its full request rate once its FIFO is primed.
- Simultaneous dequeue and enqueue on the same FIFO in one cycle: both happen and the count is unchanged.

## Configuration
- Macro `WB_SCOREBOARD_EN`.
- Defined: `pend[i]` = OR over valid FIFO entries with address i, OR'd with (`wen` && `waddr`==i). It is combinational from registered state.
- Undefined: `pend` is tied to 0 and the scoreboard logic is not built. All other behaviour is identical.

## Test plan
- Reset, then a single ALU write (addr 3, data 0x1234) → `wen`=1, `waddr`=3, `wdata`=0x1234 exactly 2 cycles after `alu_valid`; `pend[3]`=1 from the accept until `wen` falls; `busy` returns to 0 afterwards.
- ALU (addr 2) and mem (addr 5) valid together every cycle, QDEPTH=2 → issues alternate ALU, mem, ALU, …; each ready falls after its FIFO fills; no request is lost.
- ALU and mem both write addr 7 in the same cycle (ALU 0xAAAA, mem 0xBBBB) → mem is issued first and ALU second; the final register 7 value is 0xAAAA.
- ALU writes to addr 0 and addr 15 → both handshakes complete; `wen` never rises; `pend`=0 throughout.
- `lnk_valid` for 2 consecutive cycles (0x0040, 0x0050) while ALU traffic runs → `r15enable` is high for 2 consecutive cycles with `r15`=0x0040 then 0x0050; ALU issue timing is unaffected.
- Fill both FIFOs, then assert `rst` low mid-cycle → `wen`, `r15enable`, `pend` and `busy` go to 0 immediately; after release both ready signals are 1 and no stale write is issued.
